// File: rtl/cmd_issue.sv
// cmd_issue: instruction issue unit.
// Walks a synchronous instruction ROM from address 0. It keeps exactly one
// instruction outstanding toward the commit unit on the req_vaild/req_ready
// channel, then waits for the rsp_vaild/rsp_ready completion handshake.
// While an instruction executes, the word at pc+1 is prefetched, so the
// next request can go out one cycle after the acknowledge.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | after reset, waiting for start
// S_FETCH    | address 0 presented, waiting out the ROM read latency
// S_LOAD     | first word on imem_data: issue it, or end on END_WORD/stop
// S_REQ      | req_vaild/r_in held until req_ready
// S_WAIT_RSP | instruction executing; prefetch captured; timeout running
// S_ACK      | rsp_ready pulse; count the instruction and pick the next step
// S_DONE     | run finished (done=1, err valid) until the next start
module cmd_issue #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [23:0] TIMEOUT  = 24'hFF_FFFF,
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              req_vaild,
    input  logic              req_ready,
    output logic [31:0]       r_in,
    input  logic              rsp_vaild,
    output logic              rsp_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       issued_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_REQ,
        S_WAIT_RSP,
        S_ACK,
        S_DONE
    } state_t;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0]   pc_q,        pc_d;
    logic [31:0]         r_in_q,      r_in_d;
    logic                req_vaild_q, req_vaild_d;
    logic                rsp_ready_q, rsp_ready_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;
    logic [15:0]         issued_q,    issued_d;
    logic                stop_q,      stop_d;
    logic [23:0]         tcnt_q,      tcnt_d;
    logic [31:0]         pf_q,        pf_d;
    logic                pf_valid_q,  pf_valid_d;

    logic [23:0]         tcnt_inc;
    logic                pc_last;
    logic                stop_hit;
    logic [31:0]         pf_word;
    logic                fin;
    logic                fin_err;

    // Next-state and next-output computation for the whole issue sequence.
    always_comb begin
        state_d     = state_q;
        imem_addr_d = imem_addr_q;
        pc_d        = pc_q;
        r_in_d      = r_in_q;
        req_vaild_d = req_vaild_q;
        rsp_ready_d = rsp_ready_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        issued_d    = issued_q;
        stop_d      = stop_q;
        tcnt_d      = tcnt_q;
        pf_d        = pf_q;
        pf_valid_d  = pf_valid_q;
        fin         = 1'b0;
        fin_err     = 1'b0;

        tcnt_inc = tcnt_q + 24'd1;
        pc_last  = &pc_q;
        // A stop arriving in the same cycle as the decision counts as latched.
        stop_hit = stop_q | stop;
        // An early response can reach ACK before the prefetch register has
        // been loaded; the ROM output already holds the same word then.
        pf_word  = pf_valid_q ? pf_q : imem_data;

        if (busy_q && stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    imem_addr_d = '0;
                    pc_d        = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    issued_d    = '0;
                    stop_d      = 1'b0;
                    busy_d      = 1'b1;
                    pf_valid_d  = 1'b0;
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                if (stop_hit || imem_data == END_WORD) begin
                    fin = 1'b1;
                end else begin
                    r_in_d      = imem_data;
                    req_vaild_d = 1'b1;
                    state_d     = S_REQ;
                end
            end

            S_REQ: begin
                if (req_ready) begin
                    req_vaild_d = 1'b0;
                    if (!pc_last) begin
                        imem_addr_d = pc_q + ADDR_W'(1);
                    end
                    tcnt_d     = '0;
                    pf_valid_d = 1'b0;
                    state_d    = S_WAIT_RSP;
                end
            end

            S_WAIT_RSP: begin
                // tcnt_q is non-zero from the second WAIT_RSP cycle on, which is
                // when the ROM output reflects the prefetch address.
                if (tcnt_q != 24'd0 && !pf_valid_q) begin
                    pf_d       = imem_data;
                    pf_valid_d = 1'b1;
                end
                if (rsp_vaild) begin
                    rsp_ready_d = 1'b1;
                    state_d     = S_ACK;
                end else if (tcnt_inc == TIMEOUT) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end

            S_ACK: begin
                rsp_ready_d = 1'b0;
                if (issued_q != 16'hFFFF) begin
                    issued_d = issued_q + 16'd1;
                end
                if (stop_hit) begin
                    fin = 1'b1;
                end else if (pc_last) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (pf_word == END_WORD) begin
                    fin = 1'b1;
                end else begin
                    pc_d        = pc_q + ADDR_W'(1);
                    r_in_d      = pf_word;
                    req_vaild_d = 1'b1;
                    state_d     = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            err_d       = fin_err;
            req_vaild_d = 1'b0;
            rsp_ready_d = 1'b0;
        end
    end

    // State and registered outputs; reset aborts a run at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            imem_addr_q <= '0;
            pc_q        <= '0;
            r_in_q      <= '0;
            req_vaild_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            issued_q    <= '0;
            stop_q      <= 1'b0;
            tcnt_q      <= '0;
            pf_q        <= '0;
            pf_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_addr_q <= imem_addr_d;
            pc_q        <= pc_d;
            r_in_q      <= r_in_d;
            req_vaild_q <= req_vaild_d;
            rsp_ready_q <= rsp_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            issued_q    <= issued_d;
            stop_q      <= stop_d;
            tcnt_q      <= tcnt_d;
            pf_q        <= pf_d;
            pf_valid_q  <= pf_valid_d;
        end
    end

    assign imem_addr  = imem_addr_q;
    assign pc         = pc_q;
    assign r_in       = r_in_q;
    assign req_vaild  = req_vaild_q;
    assign rsp_ready  = rsp_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign issued_cnt = issued_q;

endmodule
